sram_bist_sequencer: RTL and testbench
======================================

// Module: sram_bist_sequencer
// PURPOSE
//  Upstream command source for the DE2 SRAM controller (256Kx16). Fills SRAM with an address-derived
//  pattern, reads every word back, compares, and counts mismatches. Drives the controller through a
//  req/ack command handshake and consumes its read-data return. Result goes to LEDs/7-seg logic.
// PARAMETERS
//  ADDR_W     18   SRAM word-address width; sweep covers 0 .. 2**ADDR_W-1
//  DATA_W     16   SRAM data width
//  ERR_W      16   Error_Count width (saturating)
// PORTS
//  Clock           in   1       system clock (same domain as SRAM controller)
//  Reset           in   1       synchronous, active-high
//  Start           in   1       1-cycle pulse; begins run when idle
//  Abort           in   1       stop run; return to IDLE, Done stays 0
//  Mode            in   2       00 fill+check, 01 fill only, 10 check only, 11 = fill+check
//  Req             out  1       command valid to controller
//  Req_Write       out  1       1 write, 0 read (valid with Req)
//  Req_Address     out  ADDR_W  command address
//  Req_Wdata       out  DATA_W  write data (don't-care on reads, driven 0)
//  Ack             in   1       controller accepts command this cycle
//  Rd_Valid        in   1       read data returned this cycle
//  Rd_Data         in   DATA_W  read data
//  Busy            out  1       run in progress
//  Done            out  1       run completed; held until next Start or Reset
//  Pass            out  1       Done && Error_Count==0
//  Error_Count     out  ERR_W   mismatches this run, saturates at all-ones
//  Fail_Address    out  ADDR_W  address of first mismatch (valid when Error_Count!=0)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE. Reset mid-run drops Req the next cycle, no handshake completion.
//  Pattern: P(a) = a[15:0] ^ {8{a[17:16]}} (upper bits folded; for ADDR_W<=16, P(a)=a zero-extended).
//  FSM: IDLE -> (Start) WR_PASS or RD_PASS per Mode; WR_PASS -> RD_PASS (Mode 00/11) or DONE (01);
//   RD_PASS <-> RD_WAIT per word; last word checked -> DONE; DONE -> (Start) new run.
//  Start: clears Error_Count, Fail_Address, Done; address counter=0; Busy=1 next cycle. Ignored while Busy.
//  Handshake: Req, Req_Write, Req_Address, Req_Wdata stable while Req=1 and Ack=0. Transfer on Req&&Ack.
//   WR_PASS: Req held every cycle; address +1 per transfer; Req may stay high back-to-back.
//   RD_PASS: issue read; on transfer deassert Req, enter RD_WAIT. One outstanding read max.
//   RD_WAIT: first Rd_Valid compares Rd_Data vs P(addr); mismatch -> Error_Count+1 (sat), Fail_Address
//    loaded only if Error_Count==0. Then address+1 and back to RD_PASS.
//  Rd_Valid outside RD_WAIT ignored; Rd_Valid earliest 1 cycle after read transfer.
//  Wrap: transfer/check at address 2**ADDR_W-1 ends the pass; counter wraps to 0 for next pass.
//  Abort (priority over Start, below Reset): Req=0 next cycle, Busy=0, Done=0, counts retained.
//  Start and Abort same cycle in IDLE: Abort wins, stay IDLE.
//  Ack while Req=0: ignored. Busy=1 from cycle after Start until cycle DONE entered.
// CONFIGURATION
//  SRAM_BIST_INVERT_EN defined: after the first check pass (Mode 00/11), a second write pass with ~P(a)
//   and a second check pass against ~P(a) run before DONE; Error_Count accumulates across both.
//   Fail_Address remains first failure overall. Mode 01/10 unaffected.
//  Undefined: single write/check pair only.
// STRUCTURE
//  Package sram_bist_pkg: FSM state enum (IDLE, WR_PASS, RD_PASS, RD_WAIT, DONE, and with INVERT the pass
//   select bit), Mode encodings, pattern function.
//  Sub-module sram_bist_checker: compare + saturating error counter + first-fail capture.
// TESTING (ADDR_W=4, ERR_W=4, responsive controller model with 0-2 cycle random Ack/Rd_Valid delay)
//  1 Mode 00, clean memory model -> 16 writes data==addr, 16 reads, Done=1, Pass=1, Error_Count=0.
//  2 Model corrupts addr 5 and 9 -> Error_Count=2, Fail_Address=5, Pass=0.
//  3 Model corrupts all 16, ERR_W=4 -> Error_Count=15 (saturated), Fail_Address=0.
//  4 Ack held low 10 cycles on addr 3 write -> Req/Req_Address=3/Req_Wdata=3 stable throughout.
//  5 Abort at addr 7 of RD_PASS -> Req=0 next cycle, Busy=0, Done=0; new Start reruns from addr 0.
//  6 SRAM_BIST_INVERT_EN, clean model -> second pass writes 0xFFFF..0xFFF0, 64 transfers total, Pass=1.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// -----------------------------------------------------------------------------
// sram_bist_pkg
// Shared types and helpers for the SRAM BIST sequencer:
//   state_e   - sequencer FSM states
//   mode_e    - run mode encodings presented on the Mode input
//   pass_e    - true/inverted pattern select (only with SRAM_BIST_INVERT_EN)
//   pattern() - address-derived test pattern P(a)
// Configuration macro: SRAM_BIST_INVERT_EN adds the inverted-pattern pass type.
// -----------------------------------------------------------------------------
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_PASS = 3'd1,
    ST_RD_PASS = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_FILL_CHECK     = 2'b00,
    MODE_FILL_ONLY      = 2'b01,
    MODE_CHECK_ONLY     = 2'b10,
    MODE_FILL_CHECK_ALT = 2'b11
  } mode_e;

`ifdef SRAM_BIST_INVERT_EN
  // Selects which pattern polarity the current write/check pair uses.
  typedef enum logic {
    PASS_TRUE = 1'b0,
    PASS_INV  = 1'b1
  } pass_e;
`endif

  // P(a): low 16 address bits with the two upper bits folded in across every
  // byte-lane pair. Narrow address spaces (<= 16 bits) use the address as is.
  function automatic logic [15:0] pattern(input logic [17:0] addr, input int addr_w);
    logic [15:0] p;
    p = addr[15:0];
    if (addr_w > 16) begin
      p = p ^ {8{addr[17:16]}};
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// -----------------------------------------------------------------------------
// sram_bist_checker
// Compares returned read data against the expected pattern, keeps a
// saturating mismatch counter and captures the address of the first mismatch.
// Ports:
//   Clock, Reset   - system clock, synchronous active-high reset
//   clear_i        - clears counter and captured address (new run)
//   check_i        - one compare this cycle
//   addr_i         - address of the word being checked
//   expected_i     - expected data
//   actual_i       - data returned by the SRAM controller
//   err_count_o    - mismatch count, saturates at all-ones
//   fail_addr_o    - address of the first mismatch since clear
// -----------------------------------------------------------------------------
module sram_bist_checker #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              clear_i,
  input  logic              check_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] expected_i,
  input  logic [DATA_W-1:0] actual_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    err_d  = err_q;
    fail_d = fail_q;
    if (clear_i) begin
      err_d  = '0;
      fail_d = '0;
    end else if (check_i && (actual_i != expected_i)) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      // Only the very first failure of the run is recorded.
      if (err_q == '0) begin
        fail_d = addr_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = fail_q;

endmodule

// File: rtl/sram_bist_sequencer.sv
// -----------------------------------------------------------------------------
// sram_bist_sequencer
// Command source for the SRAM controller: fills memory with P(a), reads every
// word back, compares and counts mismatches.
// Ports:
//   Clock, Reset            - system clock, synchronous active-high reset
//   Start, Abort, Mode      - run control (Abort has priority over Start)
//   Req, Req_Write,
//   Req_Address, Req_Wdata  - command to controller, held while Req && !Ack
//   Ack                     - controller accepts command (transfer = Req && Ack)
//   Rd_Valid, Rd_Data       - read data return
//   Busy, Done, Pass        - run status
//   Error_Count             - saturating mismatch count for this run
//   Fail_Address            - address of first mismatch
// Configuration macro: SRAM_BIST_INVERT_EN - in fill+check modes, a second
// write/check pair with ~P(a) runs before DONE.
// -----------------------------------------------------------------------------
module sram_bist_sequencer
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [1:0]        Mode,
  output logic              Req,
  output logic              Req_Write,
  output logic [ADDR_W-1:0] Req_Address,
  output logic [DATA_W-1:0] Req_Wdata,
  input  logic              Ack,
  input  logic              Rd_Valid,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  Error_Count,
  output logic [ADDR_W-1:0] Fail_Address
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_addr;
  logic              clear_en;
  logic              check_en;
  logic [15:0]       pat_base;
  logic [15:0]       pat_cur;
  logic [DATA_W-1:0] exp_data;

`ifdef SRAM_BIST_INVERT_EN
  pass_e pass_q, pass_d;
`endif

  assign last_addr = (addr_q == '1);
  assign pat_base  = pattern(18'(addr_q), ADDR_W);

`ifdef SRAM_BIST_INVERT_EN
  assign pat_cur = (pass_q == PASS_INV) ? ~pat_base : pat_base;
`else
  assign pat_cur = pat_base;
`endif

  assign exp_data = DATA_W'(pat_cur);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    clear_en = 1'b0;
    check_en = 1'b0;
`ifdef SRAM_BIST_INVERT_EN
    pass_d   = pass_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start && !Abort) begin
          mode_d   = mode_e'(Mode);
          addr_d   = '0;
          clear_en = 1'b1;
`ifdef SRAM_BIST_INVERT_EN
          pass_d   = PASS_TRUE;
`endif
          state_d  = (mode_e'(Mode) == MODE_CHECK_ONLY) ? ST_RD_PASS : ST_WR_PASS;
        end
      end

      ST_WR_PASS: begin
        if (Ack) begin
          // The counter wraps to 0 at the top, ready for the following pass.
          addr_d = addr_q + 1'b1;
          if (last_addr) begin
            state_d = (mode_q == MODE_FILL_ONLY) ? ST_DONE : ST_RD_PASS;
          end
        end
      end

      ST_RD_PASS: begin
        if (Ack) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (Rd_Valid) begin
          check_en = 1'b1;
          addr_d   = addr_q + 1'b1;
          if (last_addr) begin
            state_d = ST_DONE;
`ifdef SRAM_BIST_INVERT_EN
            if ((pass_q == PASS_TRUE) && (mode_q != MODE_CHECK_ONLY)) begin
              pass_d  = PASS_INV;
              state_d = ST_WR_PASS;
            end
`endif
          end else begin
            state_d = ST_RD_PASS;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort outranks everything except reset; counts are left as they are.
    if (Abort) begin
      check_en = 1'b0;
      if (Busy) begin
        state_d = ST_IDLE;
        addr_d  = addr_q;
      end
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and is not part of the sensitivity list.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FILL_CHECK;
      addr_q  <= '0;
`ifdef SRAM_BIST_INVERT_EN
      pass_q  <= PASS_TRUE;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
`ifdef SRAM_BIST_INVERT_EN
      pass_q  <= pass_d;
`endif
    end
  end

  sram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) u_checker (
    .Clock       (Clock),
    .Reset       (Reset),
    .clear_i     (clear_en),
    .check_i     (check_en),
    .addr_i      (addr_q),
    .expected_i  (exp_data),
    .actual_i    (Rd_Data),
    .err_count_o (Error_Count),
    .fail_addr_o (Fail_Address)
  );

  // Command outputs come straight from state, so they cannot move while the
  // controller withholds Ack.
  assign Req          = (state_q == ST_WR_PASS) || (state_q == ST_RD_PASS);
  assign Req_Write    = (state_q == ST_WR_PASS);
  assign Req_Address  = addr_q;
  assign Req_Wdata    = (state_q == ST_WR_PASS) ? exp_data : '0;
  assign Busy         = (state_q == ST_WR_PASS) || (state_q == ST_RD_PASS) ||
                        (state_q == ST_RD_WAIT);
  assign Done         = (state_q == ST_DONE);
  assign Pass         = Done && (Error_Count == '0);

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_bist_sequencer
// Bench for sram_bist_sequencer with ADDR_W=4, DATA_W=16, ERR_W=4. A
// responsive controller model (random 0-2 cycle Ack delay, 1-3 cycle read
// return) keeps a 16-word memory with per-address read corruption. Expected
// transfer sequences and error results come from a pass-list model.
// Honours SRAM_BIST_INVERT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_sram_bist_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int ERR_W  = 4;
  localparam int DEPTH  = 16;
  localparam logic [DATA_W-1:0] FLIP = 16'h0100;

  logic              Clock = 1'b0;
  logic              Reset, Start, Abort;
  logic [1:0]        Mode;
  logic              Req, Req_Write;
  logic [ADDR_W-1:0] Req_Address;
  logic [DATA_W-1:0] Req_Wdata;
  logic              Ack, Rd_Valid;
  logic [DATA_W-1:0] Rd_Data;
  logic              Busy, Done, Pass;
  logic [ERR_W-1:0]  Error_Count;
  logic [ADDR_W-1:0] Fail_Address;

  sram_bist_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
    .Req(Req), .Req_Write(Req_Write), .Req_Address(Req_Address), .Req_Wdata(Req_Wdata),
    .Ack(Ack), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
    .Busy(Busy), .Done(Done), .Pass(Pass),
    .Error_Count(Error_Count), .Fail_Address(Fail_Address)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Controller model state
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] corrupt [DEPTH];
  logic [31:0]       log_q [$];
  int hold_addr    = -1;
  int hold_left    = 0;
  int hold_samples = 0;
  int hold_bad     = 0;

  // Reference results
  logic [31:0] exp_q [$];
  int          exp_err;
  int          exp_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a, input bit inv);
    logic [15:0] p;
    p = 16'(a);
    return inv ? ~p : p;
  endfunction

  function automatic logic [31:0] pack(input bit wr, input int a, input logic [15:0] d);
    return {11'd0, wr, 4'(a), d};
  endfunction

  // Passes: 0 = write P, 1 = check P, 2 = write ~P, 3 = check ~P.
  task automatic build_model(input logic [1:0] mode);
    logic [DATA_W-1:0] mm [DEPTH];
    int passes [$];
    for (int a = 0; a < DEPTH; a++) mm[a] = mem[a];
    exp_q.delete();
    exp_err  = 0;
    exp_fail = 0;
    case (mode)
      2'b01:   passes = {0};
      2'b10:   passes = {1};
      default: begin
        passes = {0, 1};
`ifdef SRAM_BIST_INVERT_EN
        passes.push_back(2);
        passes.push_back(3);
`endif
      end
    endcase
    foreach (passes[p]) begin
      for (int a = 0; a < DEPTH; a++) begin
        bit inv;
        inv = (passes[p] >= 2);
        if (passes[p] % 2 == 0) begin
          mm[a] = pat(a, inv);
          exp_q.push_back(pack(1'b1, a, pat(a, inv)));
        end else begin
          exp_q.push_back(pack(1'b0, a, 16'h0));
          if ((mm[a] ^ corrupt[a]) != pat(a, inv)) begin
            if (exp_err == 0) exp_fail = a;
            exp_err++;
          end
        end
      end
    end
    if (exp_err > 15) exp_err = 15;
  endtask

  // Controller model: decides Ack / Rd_Valid on the falling edge for the
  // following rising edge, and records each transfer it grants.
  initial begin
    int ack_dly;
    int rd_cnt;
    logic [DATA_W-1:0] rd_val;
    ack_dly = -1; rd_cnt = 0; rd_val = '0;
    Ack = 1'b0; Rd_Valid = 1'b0; Rd_Data = '0;
    forever begin
      @(negedge Clock);
      Ack = 1'b0;
      Rd_Valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          Rd_Valid = 1'b1;
          Rd_Data  = rd_val;
        end
      end
      if (hold_left > 0 && (hold_samples > 0 ||
          (Req && Req_Write && int'(Req_Address) == hold_addr))) begin
        if (!(Req === 1'b1 && Req_Write === 1'b1 && int'(Req_Address) == hold_addr &&
              Req_Wdata === pat(hold_addr, 1'b0)))
          hold_bad++;
        hold_samples++;
        hold_left--;
        ack_dly = -1;
      end else if (!Req) begin
        ack_dly = -1;
      end else begin
        if (ack_dly < 0) ack_dly = int'($urandom_range(0, 2));
        if (ack_dly == 0) begin
          Ack = 1'b1;
          ack_dly = -1;
          if (Req_Write) begin
            mem[Req_Address] = Req_Wdata;
            log_q.push_back(pack(1'b1, int'(Req_Address), Req_Wdata));
          end else begin
            rd_val = mem[Req_Address] ^ corrupt[Req_Address];
            rd_cnt = int'($urandom_range(1, 3));
            log_q.push_back(pack(1'b0, int'(Req_Address), Req_Wdata));
          end
        end else begin
          ack_dly--;
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] mode);
    @(negedge Clock);
    Start = 1'b1;
    Mode  = mode;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic do_run(input string name, input logic [1:0] mode, input int poke);
    bit done_seen;
    build_model(mode);
    log_q.delete();
    pulse_start(mode);
    check({name, "_busy"}, 32'(Busy), 32'd1);
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (Done) begin
        done_seen = 1'b1;
      end else begin
        Start = (cyc == poke);
        if (cyc == poke) Mode = ~mode;
        @(negedge Clock);
      end
    end
    Start = 1'b0;
    check({name, "_done"}, 32'(done_seen), 32'd1);
    check({name, "_nxfer"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_xfer%0d", name, i), log_q[i], exp_q[i]);
    check({name, "_errcnt"}, 32'(Error_Count), 32'(exp_err));
    check({name, "_failaddr"}, 32'(Fail_Address), 32'(exp_fail));
    check({name, "_pass"}, 32'(Pass), 32'(exp_err == 0));
    repeat (3) @(negedge Clock);
    check({name, "_done_held"}, 32'(Done), 32'd1);
    check({name, "_busy_off"}, 32'(Busy), 32'd0);
  endtask

  task automatic wait_read(input int addr, output bit found);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge Clock);
      if (Req && !Req_Write && int'(Req_Address) == addr) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = '0;
      corrupt[a] = '0;
    end
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 2'b00;
    repeat (3) @(negedge Clock);
    check("rst_req", 32'(Req), 32'd0);
    check("rst_req_write", 32'(Req_Write), 32'd0);
    check("rst_req_addr", 32'(Req_Address), 32'd0);
    check("rst_req_wdata", 32'(Req_Wdata), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_pass", 32'(Pass), 32'd0);
    check("rst_errcnt", 32'(Error_Count), 32'd0);
    check("rst_failaddr", 32'(Fail_Address), 32'd0);
    Reset = 1'b0;

    // Start and Abort together while idle: Abort wins.
    @(negedge Clock);
    Start = 1'b1; Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Abort = 1'b0;
    check("start_abort_busy", 32'(Busy), 32'd0);
    check("start_abort_req", 32'(Req), 32'd0);
    repeat (2) @(negedge Clock);
    check("start_abort_idle", 32'(Busy), 32'd0);

    // Clean fill+check.
    do_run("clean00", 2'b00, -1);

    // Two corrupted words.
    corrupt[5] = FLIP;
    corrupt[9] = FLIP;
    do_run("corrupt59", 2'b00, -1);

    // Everything corrupted, mode 11: counter saturates.
    for (int a = 0; a < DEPTH; a++) corrupt[a] = FLIP;
    do_run("corrupt_all", 2'b11, -1);
    for (int a = 0; a < DEPTH; a++) corrupt[a] = '0;

    // Fill only with Ack withheld 10 cycles on address 3, plus a Start
    // pulse mid-run that must be ignored.
    hold_addr = 3; hold_left = 10; hold_samples = 0; hold_bad = 0;
    do_run("fill_hold", 2'b01, 20);
    check("hold_samples", 32'(hold_samples), 32'd10);
    check("hold_stable", 32'(hold_bad), 32'd0);
    hold_left = 0;

    // Check only against the pattern just written, one bad word.
    corrupt[12] = FLIP;
    do_run("check_only", 2'b10, -1);
    corrupt[12] = '0;

    // Abort at read of address 7.
    corrupt[2] = FLIP;
    log_q.delete();
    pulse_start(2'b00);
    wait_read(7, found);
    check("abort_reach_rd7", 32'(found), 32'd1);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    check("abort_req", 32'(Req), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_errcnt", 32'(Error_Count), 32'd1);
    check("abort_failaddr", 32'(Fail_Address), 32'd2);
    repeat (5) @(negedge Clock);
    check("abort_stays_idle", 32'(Busy), 32'd0);
    corrupt[2] = '0;
    do_run("rerun", 2'b00, -1);

    // Reset in the middle of the read pass.
    corrupt[1] = FLIP;
    pulse_start(2'b00);
    wait_read(3, found);
    check("midrst_reach_rd3", 32'(found), 32'd1);
    check("midrst_pre_errcnt", 32'(Error_Count), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("midrst_req", 32'(Req), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_errcnt", 32'(Error_Count), 32'd0);
    check("midrst_addr", 32'(Req_Address), 32'd0);
    Reset = 1'b0;
    corrupt[1] = '0;
    repeat (5) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
